uart_status_tx: RTL and testbench

- Transmit-side counterpart of the game's UART command link: sends a fixed-format ASCII status line (game state, control code, score) to the host over uart_tx.
- Sits beside the control block in the top level and takes the same state/control/score signals that drive the LCD.
- A send pulse snapshots the inputs and serializes one 15-byte message as 8N1 frames.

---
 rtl/uart_status_tx_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 95 +++++++++
 rtl/uart_status_tx.sv | 105 ++++++++++
 tb/tb_uart_status_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_status_tx_pkg.sv
// Shared types and helpers for the UART status-line transmitter.
package uart_status_tx_pkg;

  localparam int unsigned STATUS_LEN = 15;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'(8'h30 + {4'h0, n});
    else           return 8'(8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake; ready asserts in IDLE and on
// the last stop-bit cycle so consecutive bytes go out with no idle gap.
module uart_tx_byte
  import uart_status_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready_c,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             tx_nxt;
  logic             bit_end_c;

  assign bit_end_c = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
      tx      <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (state == IDLE || bit_end_c) ? '0 : cnt + CNT_W'(1);
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    tx_nxt    = tx;
    ready_c   = 1'b0;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        tx_nxt  = 1'b1;
      end
      START: begin
        if (bit_end_c) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          sh_nxt    = {1'b0, shreg[7:1]};
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_idx + 3'd1;
            tx_nxt  = shreg[0];
            sh_nxt  = {1'b0, shreg[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          ready_c   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new byte overrides the IDLE/STOP exit and starts its start bit at once.
    if (ready_c && valid) begin
      state_nxt = START;
      cnt_nxt   = '0;
      sh_nxt    = data;
      tx_nxt    = 1'b0;
    end
  end

endmodule

// File: rtl/uart_status_tx.sv
// Sends the ASCII status line "Sss Ccc Pdddd\r\n" over UART on request,
// snapshotting the inputs and coalescing requests made while busy.
module uart_status_tx
  import uart_status_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send,
  input  logic [7:0]  state,
  input  logic [7:0]  ctrl,
  input  logic [15:0] score,
  output logic        busy,
  output logic        uart_tx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STATUS_LEN - 1);

  logic [7:0]       snap_state, snap_ctrl;
  logic [15:0]      snap_score;
  logic             pending;
  logic [IDX_W-1:0] byte_idx;

  logic             byte_ready_c, byte_valid_c, restart_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic [7:0]       byte_data_c;

  // A request arriving on the final stop cycle counts toward the next message.
  assign restart_c    = pending || send;
  assign byte_valid_c = busy ? (byte_ready_c && (byte_idx != LAST_IDX || restart_c)) : send;
  assign sel_idx_c    = (!busy || byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);

  always_comb begin
    byte_data_c = 8'h0A;
    case (sel_idx_c)
      4'd0:    byte_data_c = "S";
      4'd1:    byte_data_c = hex_ascii(snap_state[7:4]);
      4'd2:    byte_data_c = hex_ascii(snap_state[3:0]);
      4'd3:    byte_data_c = " ";
      4'd4:    byte_data_c = "C";
      4'd5:    byte_data_c = hex_ascii(snap_ctrl[7:4]);
      4'd6:    byte_data_c = hex_ascii(snap_ctrl[3:0]);
      4'd7:    byte_data_c = " ";
      4'd8:    byte_data_c = "P";
      4'd9:    byte_data_c = hex_ascii(snap_score[15:12]);
      4'd10:   byte_data_c = hex_ascii(snap_score[11:8]);
      4'd11:   byte_data_c = hex_ascii(snap_score[7:4]);
      4'd12:   byte_data_c = hex_ascii(snap_score[3:0]);
      4'd13:   byte_data_c = 8'h0D;
      default: byte_data_c = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      pending    <= 1'b0;
      byte_idx   <= '0;
      snap_state <= '0;
      snap_ctrl  <= '0;
      snap_score <= '0;
    end else if (!busy) begin
      if (send) begin
        busy       <= 1'b1;
        pending    <= 1'b0;
        byte_idx   <= '0;
        snap_state <= state;
        snap_ctrl  <= ctrl;
        snap_score <= score;
      end
    end else if (byte_ready_c) begin
      if (byte_idx != LAST_IDX) begin
        byte_idx <= byte_idx + IDX_W'(1);
        pending  <= pending | send;
      end else if (restart_c) begin
        byte_idx   <= '0;
        pending    <= 1'b0;
        snap_state <= state;
        snap_ctrl  <= ctrl;
        snap_score <= score;
      end else begin
        busy     <= 1'b0;
        byte_idx <= '0;
        pending  <= 1'b0;
      end
    end else if (send) begin
      pending <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (byte_valid_c),
    .data    (byte_data_c),
    .ready_c (byte_ready_c),
    .tx      (uart_tx)
  );

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx at 10 clocks per bit.
module tb_uart_status_tx;

  typedef logic [119:0] msg_t;
  localparam int MSG_CYC = 1500;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        send = 1'b0;
  logic [7:0]  state = 8'h00;
  logic [7:0]  ctrl = 8'h00;
  logic [15:0] score = 16'h0000;
  logic        busy;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;
  bit hold = 1'b0;

  always #5 clk = ~clk;

  uart_status_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .send    (send),
    .state   (state),
    .ctrl    (ctrl),
    .score   (score),
    .busy    (busy),
    .uart_tx (uart_tx)
  );

  // Receives one message starting at the first start-bit cycle; returns at the
  // negedge of the cycle after the last stop-bit cycle. Applies timed stimulus.
  task automatic rx_msg(input int p1, input int p2,
                        input int sc1_cyc, input logic [15:0] sc1_val,
                        input int sc2_cyc, input logic [15:0] sc2_val,
                        output msg_t msg, output bit width_ok,
                        output bit frame_ok, output int busy_cyc);
    logic [7:0] cur;
    logic       bitval;
    int         bi;
    int         sub;
    msg = '0; width_ok = 1'b1; frame_ok = 1'b1; busy_cyc = 0;
    cur = '0; bitval = 1'b1;
    for (int c = 0; c < MSG_CYC; c++) begin
      bi  = (c % 100) / 10;
      sub = c % 10;
      if (busy === 1'b1) busy_cyc++;
      if (sub == 0) begin
        bitval = uart_tx;
        if (bi == 0 && bitval !== 1'b0) frame_ok = 1'b0;
        if (bi == 9 && bitval !== 1'b1) frame_ok = 1'b0;
        if (bi >= 1 && bi <= 8) cur[bi-1] = bitval;
      end else if (uart_tx !== bitval) begin
        width_ok = 1'b0;
      end
      if (c % 100 == 99) msg = {msg[111:0], cur};
      send = hold || (c == p1) || (c == p2);
      if (c == sc1_cyc) score = sc1_val;
      if (c == sc2_cyc) score = sc2_val;
      @(negedge clk);
    end
  endtask

  task automatic pulse();
    send = 1'b1;
    @(negedge clk);
    send = hold;
  endtask

  task automatic test_reset();
    bit bad;
    reset_n = 1'b0;
    send = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx: got %b want 1", uart_tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL idle_50: got activity want tx=1 busy=0");
    end
  endtask

  task automatic test_single();
    msg_t m, e;
    bit w, f;
    int b;
    e = {"S03 C1A P0BEF", 8'h0D, 8'h0A};
    state = 8'h03; ctrl = 8'h1A; score = 16'h0BEF;
    @(negedge clk);
    pulse();
    checks++;
    if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_first_start: got tx=%b busy=%b want tx=0 busy=1", uart_tx, busy);
    end
    rx_msg(-1, -1, -1, 16'h0, -1, 16'h0, m, w, f, b);
    checks++;
    if (m !== e) begin
      failures++; $display("FAIL single_msg: got %h want %h", m, e);
    end
    checks++;
    if (!w || !f) begin
      failures++; $display("FAIL single_framing: got width_ok=%0d frame_ok=%0d want 1 1", w, f);
    end
    checks++;
    if (b !== 1500) begin
      failures++; $display("FAIL single_busy_len: got %0d want 1500", b);
    end
    checks++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      failures++; $display("FAIL single_end_idle: got busy=%b tx=%b want 0 1", busy, uart_tx);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_snapshot();
    msg_t m, e;
    bit w, f;
    int b;
    e = {"S03 C1A P0BEF", 8'h0D, 8'h0A};
    state = 8'h03; ctrl = 8'h1A; score = 16'h0BEF;
    pulse();
    rx_msg(-1, -1, 200, 16'hFFFF, -1, 16'h0, m, w, f, b);
    checks++;
    if (m !== e) begin
      failures++; $display("FAIL snapshot_msg: got %h want %h", m, e);
    end
    checks++;
    if (!w || !f || b !== 1500) begin
      failures++; $display("FAIL snapshot_frame: got w=%0d f=%0d busy=%0d want 1 1 1500", w, f, b);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    msg_t m1, m2, e1, e2;
    bit w1, f1, w2, f2, bad;
    int b1, b2;
    e1 = {"S03 C1A P0BEF", 8'h0D, 8'h0A};
    e2 = {"S03 C1A P0002", 8'h0D, 8'h0A};
    state = 8'h03; ctrl = 8'h1A; score = 16'h0BEF;
    pulse();
    rx_msg(300, 700, 600, 16'h0001, 1400, 16'h0002, m1, w1, f1, b1);
    checks++;
    if (busy !== 1'b1 || uart_tx !== 1'b0) begin
      failures++; $display("FAIL b2b_no_gap: got busy=%b tx=%b want 1 0", busy, uart_tx);
    end
    rx_msg(-1, -1, -1, 16'h0, -1, 16'h0, m2, w2, f2, b2);
    checks++;
    if (m1 !== e1) begin
      failures++; $display("FAIL b2b_msg1: got %h want %h", m1, e1);
    end
    checks++;
    if (m2 !== e2) begin
      failures++; $display("FAIL b2b_msg2: got %h want %h", m2, e2);
    end
    checks++;
    if (b1 + b2 !== 3000 || !w1 || !w2 || !f1 || !f2) begin
      failures++; $display("FAIL b2b_busy: got busy=%0d framing=%0d%0d%0d%0d want 3000 1111", b1 + b2, w1, f1, w2, f2);
    end
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b0 || uart_tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL b2b_only_two: got third message want idle");
    end
  endtask

  task automatic test_reset_mid();
    msg_t m, e;
    bit w, f;
    int b;
    e = {"S03 C1A P0BEF", 8'h0D, 8'h0A};
    state = 8'h03; ctrl = 8'h1A; score = 16'h0BEF;
    pulse();
    repeat (535) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid: got tx=%b busy=%b want 1 0", uart_tx, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle: got tx=%b busy=%b want 1 0", uart_tx, busy);
    end
    pulse();
    rx_msg(-1, -1, -1, 16'h0, -1, 16'h0, m, w, f, b);
    checks++;
    if (m !== e || !w || !f || b !== 1500) begin
      failures++; $display("FAIL reset_mid_msg: got %h busy=%0d want %h busy=1500", m, b, e);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_held();
    msg_t m1, m2, m3, e;
    bit w1, f1, w2, f2, w3, f3, gap_bad;
    int b1, b2, b3;
    e = {"SAB C5C P1234", 8'h0D, 8'h0A};
    state = 8'hAB; ctrl = 8'h5C; score = 16'h1234;
    hold = 1'b1;
    pulse();
    rx_msg(-1, -1, -1, 16'h0, -1, 16'h0, m1, w1, f1, b1);
    gap_bad = (busy !== 1'b1 || uart_tx !== 1'b0);
    rx_msg(-1, -1, -1, 16'h0, -1, 16'h0, m2, w2, f2, b2);
    if (busy !== 1'b1 || uart_tx !== 1'b0) gap_bad = 1'b1;
    hold = 1'b0;
    send = 1'b0;
    rx_msg(-1, -1, -1, 16'h0, -1, 16'h0, m3, w3, f3, b3);
    checks++;
    if (gap_bad) begin
      failures++; $display("FAIL held_no_gap: got idle between messages want none");
    end
    checks++;
    if (m1 !== e || m2 !== e || m3 !== e) begin
      failures++; $display("FAIL held_msgs: got %h %h %h want %h", m1, m2, m3, e);
    end
    checks++;
    if (b1 + b2 + b3 !== 4500 || !(w1 && w2 && w3 && f1 && f2 && f3)) begin
      failures++; $display("FAIL held_busy: got busy=%0d want 4500 with clean framing", b1 + b2 + b3);
    end
    checks++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      failures++; $display("FAIL held_release: got busy=%b tx=%b want 0 1", busy, uart_tx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
